// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle RV32I-subset control FSM; optional macro ILLEGAL_TRAP_EN
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_control,
    output logic [3:0]  state_o,
    output logic        illegal,
    output logic        mem_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_mem_err;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_r;
    logic       w_is_andi;
    logic       w_is_mem;
    logic       w_is_beq;
    logic       w_wait_state;
    logic       w_timeout;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    // Only the three R-type forms with funct7 = 0 are supported; others are illegal at decode.
    assign w_is_r    = (w_opcode == 7'b0110011) && (w_funct7 == 7'b0000000) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b110) || (w_funct3 == 3'b001));
    assign w_is_andi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b111);
    assign w_is_mem  = (w_opcode == 7'b0000011) || (w_opcode == 7'b0100011);
    assign w_is_beq  = (w_opcode == 7'b1100011) && (w_funct3 == 3'b000);

    // Memory-wait states share one timeout counter; mem_ready on the limit cycle still wins.
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout    = w_wait_state && !mem_ready && (r_cnt == LP_TIMEOUT);

    assign state_o = r_state;
    assign illegal = r_illegal;
    assign mem_err = r_mem_err;

    // State register, timeout counter and sticky trap flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_wait_state && !mem_ready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            if ((r_state == S_DECODE) && (w_next == S_TRAP)) begin
                r_illegal <= 1'b1;
            end
`endif
        end
    end

    // Next-state and per-state datapath control decode.
    always_comb begin
        w_next      = r_state;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ir_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (w_is_r) begin
                    w_next = S_EXEC_R;
                end else if (w_is_andi) begin
                    w_next = S_EXEC_I;
                end else if (w_is_mem) begin
                    w_next = S_ADDR;
                end else if (w_is_beq) begin
                    w_next = S_BRANCH;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                case (w_funct3)
                    3'b110:  alu_control = ALU_OR;
                    3'b001:  alu_control = ALU_SLL;
                    default: alu_control = ALU_ADD;
                endcase
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_AND;
                w_next      = S_WB_ALU;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // opcode bit 5 separates sw (0100011) from lw (0000011)
                w_next    = w_opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                w_next    = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 1'b1;
                pc_write    = zero;
                w_next      = S_FETCH;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized trace-model bench for mc_control_fsm
module tb_mc_control_fsm;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_src, ir_write, iord, mem_read, mem_write;
    logic        reg_write, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_control;
    logic [3:0]  state_o;
    logic        illegal, mem_err;
    logic [14:0] w_out;

    int total = 0;
    int bad = 0;
    int m_ill = 0;
    int m_merr = 0;

    mc_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .state_o(state_o), .illegal(illegal), .mem_err(mem_err)
    );

    assign w_out = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
                    mem_to_reg, alu_src_a, alu_src_b, alu_control};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction class: 0 R, 1 andi, 2 lw, 3 sw, 4 beq, 5 illegal
    function automatic int classify(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        if (op == 7'b0110011 && f7 == 7'd0 && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd1)) return 0;
        if (op == 7'b0010011 && f3 == 3'd7) return 1;
        if (op == 7'b0000011) return 2;
        if (op == 7'b0100011) return 3;
        if (op == 7'b1100011 && f3 == 3'd0) return 4;
        return 5;
    endfunction

    // Expected control word {pc_write,pc_src,ir_write,iord,mem_read,mem_write,reg_write,mem_to_reg,alu_src_a,alu_src_b,alu_control}
    function automatic logic [14:0] exp_out(input int st, input logic [31:0] ins, input logic z, input logic mr);
        logic pcw, pcs, irw, io, mrd, mwr, rw, m2r, asa;
        logic [1:0] asb;
        logic [3:0] ac;
        {pcw, pcs, irw, io, mrd, mwr, rw, m2r, asa} = 9'b0;
        asb = 2'b00;
        ac = 4'b0000;
        case (st)
            0: begin mrd = 1; asb = 2'b01; if (mr) begin irw = 1; pcw = 1; end end
            1: asb = 2'b11;
            2: begin
                asa = 1;
                if (ins[14:12] == 3'b110) ac = 4'b0001;
                else if (ins[14:12] == 3'b001) ac = 4'b0011;
            end
            3: begin asa = 1; asb = 2'b10; ac = 4'b0010; end
            4: begin asa = 1; asb = 2'b10; end
            5: begin io = 1; mrd = 1; end
            6: begin io = 1; mwr = 1; end
            7: rw = 1;
            8: begin rw = 1; m2r = 1; end
            9: begin asa = 1; ac = 4'b0100; pcs = 1; pcw = z; end
            default: ;
        endcase
        return {pcw, pcs, irw, io, mrd, mwr, rw, m2r, asa, asb, ac};
    endfunction

    function automatic logic [31:0] gen(input int k);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [2:0]  f3;
        rd = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        imm = 12'($urandom);
        case (k)
            0: begin
                case ($urandom_range(0, 2))
                    0: f3 = 3'b000;
                    1: f3 = 3'b110;
                    default: f3 = 3'b001;
                endcase
                return {7'b0, rs2, rs1, f3, rd, 7'b0110011};
            end
            1: return {imm, rs1, 3'b111, rd, 7'b0010011};
            2: return {imm, rs1, 3'b010, rd, 7'b0000011};
            3: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            4: return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b1100011};
            default: begin
                case ($urandom_range(0, 4))
                    0: return {25'($urandom), 7'h7F};
                    1: return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
                    2: return {7'b0, rs2, rs1, 3'b010, rd, 7'b0110011};
                    3: return {imm, rs1, 3'b000, rd, 7'b0010011};
                    default: return {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b1100011};
                endcase
            end
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'($urandom);
        zero = 1'($urandom);
        instr = $urandom;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ill = 0;
        m_merr = 0;
    endtask

    // Runs one instruction from FETCH. wf/wm: mem_ready-low cycles in FETCH / memory state;
    // more than TO low cycles must trap. Expected state trace is built from the class latency.
    task automatic run_instr(input string nm, input logic [31:0] ins, input int wf, input int wm, input logic zv);
        int st_q[$];
        bit lo_q[$];
        bit t_mem;
        bit t_ill;
        int k;
        int st;
        t_mem = 0;
        t_ill = 0;
        k = classify(ins);
        repeat ((wf > TO) ? TO + 1 : wf) begin st_q.push_back(0); lo_q.push_back(1); end
        if (wf > TO) begin
            st_q.push_back(10); lo_q.push_back(0); t_mem = 1;
        end else begin
            st_q.push_back(0); lo_q.push_back(0);
            st_q.push_back(1); lo_q.push_back(0);
            case (k)
                0: begin st_q.push_back(2); lo_q.push_back(0); st_q.push_back(7); lo_q.push_back(0); end
                1: begin st_q.push_back(3); lo_q.push_back(0); st_q.push_back(7); lo_q.push_back(0); end
                2, 3: begin
                    st_q.push_back(4); lo_q.push_back(0);
                    st = (k == 2) ? 5 : 6;
                    repeat ((wm > TO) ? TO + 1 : wm) begin st_q.push_back(st); lo_q.push_back(1); end
                    if (wm > TO) begin
                        st_q.push_back(10); lo_q.push_back(0); t_mem = 1;
                    end else begin
                        st_q.push_back(st); lo_q.push_back(0);
                        if (k == 2) begin st_q.push_back(8); lo_q.push_back(0); end
                    end
                end
                4: begin st_q.push_back(9); lo_q.push_back(0); end
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    st_q.push_back(10); lo_q.push_back(0); t_ill = 1;
`endif
                end
            endcase
        end
        if (t_mem || t_ill) begin
            st_q.push_back(10); lo_q.push_back(0);
            st_q.push_back(10); lo_q.push_back(0);
        end
        for (int i = 0; i < st_q.size(); i++) begin
            st = st_q[i];
            instr = ins;
            zero = zv;
            if (st == 0 || st == 5 || st == 6) mem_ready = lo_q[i] ? 1'b0 : 1'b1;
            else mem_ready = 1'($urandom);
            if (st == 10) begin
                if (t_mem) m_merr = 1;
                if (t_ill) m_ill = 1;
            end
            #1;
            total++;
            if (state_o !== 4'(st)) begin
                bad++;
                $display("FAIL %s state cyc%0d: got %0d want %0d", nm, i, state_o, st);
            end
            total++;
            if (w_out !== exp_out(st, ins, zero, mem_ready)) begin
                bad++;
                $display("FAIL %s ctrl cyc%0d st%0d: got %h want %h", nm, i, st, w_out,
                         exp_out(st, ins, zero, mem_ready));
            end
            total++;
            if ({illegal, mem_err} !== {1'(m_ill), 1'(m_merr)}) begin
                bad++;
                $display("FAIL %s flags cyc%0d: got ill=%b err=%b want ill=%0d err=%0d",
                         nm, i, illegal, mem_err, m_ill, m_merr);
            end
            @(posedge clk);
            #1;
        end
        if (t_mem || t_ill) begin
            do_reset();
            mem_ready = 1'b0;
            #1;
            total++;
            if ({state_o, illegal, mem_err} !== 6'b0) begin
                bad++;
                $display("FAIL %s post_trap_reset: got st=%0d ill=%b err=%b want 0 0 0",
                         nm, state_o, illegal, mem_err);
            end
            do_reset();
        end else begin
            total++;
            if (state_o !== 4'd0) begin
                bad++;
                $display("FAIL %s end_state: got %0d want 0", nm, state_o);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        mem_ready = 1'b0;
        #1;
        total++;
        if (state_o !== 4'd0 || illegal !== 1'b0 || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got st=%0d ill=%b err=%b want 0 0 0", state_o, illegal, mem_err);
        end
        total++;
        if (w_out !== exp_out(0, instr, zero, 1'b0)) begin
            bad++;
            $display("FAIL reset_ctrl: got %h want %h", w_out, exp_out(0, instr, zero, 1'b0));
        end
        do_reset();
    endtask

    task automatic test_add();
        run_instr("add", 32'h002081B3, 0, 0, 1'b0);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait3", 32'h0000A183, 0, 3, 1'b0);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", 32'h00208463, 0, 0, 1'b1);
        run_instr("beq_not_taken", 32'h00208463, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_instr("fetch_timeout16", 32'h002081B3, 16, 0, 1'b0);
        run_instr("fetch_ready_at_limit", 32'h002081B3, 15, 0, 1'b0);
        run_instr("lw_timeout16", 32'h0000A183, 0, 16, 1'b0);
        run_instr("sw_ready_at_limit", 32'h0020A023, 0, 15, 1'b0);
        run_instr("sw_timeout16", 32'h0020A023, 0, 16, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_7f", 32'h0000007F, 0, 0, 1'b0);
        run_instr("illegal_sub", 32'h402081B3, 1, 0, 1'b0);
        run_instr("illegal_addi", 32'h00508093, 0, 0, 1'b1);
    endtask

    task automatic test_reset_memwr();
        do_reset();
        instr = 32'h0020A023;
        zero = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++;
        if (state_o !== 4'd6 || mem_write !== 1'b1) begin
            bad++;
            $display("FAIL rst_memwr_before: got st=%0d mem_write=%b want 6 1", state_o, mem_write);
        end
        @(posedge clk);
        #1;
        total++;
        if (state_o !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b1) begin
            bad++;
            $display("FAIL rst_memwr_after: got st=%0d mw=%b mr=%b want 0 0 1",
                     state_o, mem_write, mem_read);
        end
        reset = 1'b0;
        do_reset();
    endtask

    task automatic test_random();
        int k;
        int wf;
        int wm;
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 5);
            wf = ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 3);
            wm = ($urandom_range(0, 24) == 0) ? 16 : $urandom_range(0, 4);
            run_instr("random", gen(k), wf, wm, 1'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_sw", 32'h0020A023, 0, 0, 1'b0);
        run_instr("b2b_andi", 32'h0FF0F093, 0, 0, 1'b0);
        run_instr("b2b_or", 32'h0020E1B3, 0, 0, 1'b0);
        run_instr("b2b_sll", 32'h002091B3, 0, 0, 1'b0);
        run_instr("b2b_lw", 32'h0000A183, 2, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_reset_memwr();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
